sbox_share_scheduler: RTL and testbench

SBOX_SHARE_SCHEDULER -- requirements
Module: sbox_share_scheduler

---
 rtl/sbox_share_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_sbox_share_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_share_scheduler.sv
// sbox_share_scheduler
//   Shares four AES forward S-box lanes between two requesters. The state requester
//   needs four passes, one 32-bit word per cycle. The key-expansion SubWord requester
//   needs a single pass. Only one transaction runs at a time.
//
//   Build option: define SBOX_KW_PRIORITY_EN to give kw_req fixed priority over
//   st_req. When it is undefined, simultaneous requests are granted round-robin.
//
// Ports
//   clk        : clock; all logic is on its rising edge
//   rst_n      : synchronous active-low reset
//   st_req     : state request valid; the requester holds it until st_ack
//   st_data    : 128-bit state to substitute; word 0 is [127:96]
//   st_ack     : one-cycle pulse when the state request is accepted
//   st_done    : one-cycle pulse when st_result is valid
//   st_result  : substituted state; held until the next st_done
//   kw_req     : key-word request valid; the requester holds it until kw_ack
//   kw_data    : 32-bit key word to substitute
//   kw_ack     : one-cycle pulse when the key-word request is accepted
//   kw_done    : one-cycle pulse when kw_result is valid
//   kw_result  : substituted key word; held until the next kw_done
//   busy       : high whenever the scheduler is not idle
module sbox_share_scheduler #(
    parameter int unsigned NUM_SBOX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_req,
    input  logic [127:0] st_data,
    output logic         st_ack,
    output logic         st_done,
    output logic [127:0] st_result,
    input  logic         kw_req,
    input  logic [31:0]  kw_data,
    output logic         kw_ack,
    output logic         kw_done,
    output logic [31:0]  kw_result,
    output logic         busy
);

    localparam logic [7:0] SBOX_LUT [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b,
        8'hfe, 8'hd7, 8'hab, 8'h76, 8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0, 8'hb7, 8'hfd, 8'h93, 8'h26,
        8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2,
        8'heb, 8'h27, 8'hb2, 8'h75, 8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84, 8'h53, 8'hd1, 8'h00, 8'hed,
        8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f,
        8'h50, 8'h3c, 8'h9f, 8'ha8, 8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2, 8'hcd, 8'h0c, 8'h13, 8'hec,
        8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14,
        8'hde, 8'h5e, 8'h0b, 8'hdb, 8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79, 8'he7, 8'hc8, 8'h37, 8'h6d,
        8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f,
        8'h4b, 8'hbd, 8'h8b, 8'h8a, 8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e, 8'he1, 8'hf8, 8'h98, 8'h11,
        8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f,
        8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [2:0] {
        Idle  = 3'd0,
        StSub = 3'd1,
        KwSub = 3'd2,
        StFin = 3'd3,
        KwFin = 3'd4
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     word_cnt_q;
    logic [127:0]   st_buf_q;     // captured state; words are replaced in place as they finish
    logic [31:0]    kw_buf_q;
    logic [127:0]   st_result_q;
    logic [31:0]    kw_result_q;
    logic [127:0]   st_merged;    // st_buf_q with the current word replaced by its substitution
    logic [31:0]    sub_in;
    logic [31:0]    sub_out;

`ifndef SBOX_KW_PRIORITY_EN
    logic           last_kw_q;    // 1: key word was served last, so a tie goes to the state
`endif

    // Shared substitution lanes; byte i of the output comes from byte i of the input.
    for (genvar g = 0; g < NUM_SBOX; g++) begin : g_lane
        assign sub_out[8*g +: 8] = SBOX_LUT[sub_in[8*g +: 8]];
    end

    always_comb begin
        sub_in    = kw_buf_q;
        st_merged = st_buf_q;
        if (state_q != KwSub) begin
            unique case (word_cnt_q)
                2'd0: sub_in = st_buf_q[127:96];
                2'd1: sub_in = st_buf_q[95:64];
                2'd2: sub_in = st_buf_q[63:32];
                2'd3: sub_in = st_buf_q[31:0];
                default: sub_in = st_buf_q[127:96];
            endcase
        end
        unique case (word_cnt_q)
            2'd0: st_merged[127:96] = sub_out;
            2'd1: st_merged[95:64]  = sub_out;
            2'd2: st_merged[63:32]  = sub_out;
            2'd3: st_merged[31:0]   = sub_out;
            default: st_merged[127:96] = sub_out;
        endcase
    end

    // Next state and grant decisions; acks are held off while reset is asserted.
    always_comb begin
        state_d = state_q;
        st_ack  = 1'b0;
        kw_ack  = 1'b0;
        unique case (state_q)
            Idle: begin
                if (rst_n) begin
`ifdef SBOX_KW_PRIORITY_EN
                    kw_ack = kw_req;
                    st_ack = st_req && !kw_req;
`else
                    if (st_req && kw_req) begin
                        st_ack = last_kw_q;
                        kw_ack = !last_kw_q;
                    end else begin
                        st_ack = st_req;
                        kw_ack = kw_req;
                    end
`endif
                end
                if (st_ack) begin
                    state_d = StSub;
                end else if (kw_ack) begin
                    state_d = KwSub;
                end
            end
            StSub: begin
                if (word_cnt_q == 2'd3) begin
                    state_d = StFin;
                end
            end
            StFin:   state_d = Idle;
            KwSub:   state_d = KwFin;
            KwFin:   state_d = Idle;
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= Idle;
            word_cnt_q  <= 2'd0;
            st_buf_q    <= '0;
            kw_buf_q    <= '0;
            st_result_q <= '0;
            kw_result_q <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                Idle: begin
                    if (st_ack) begin
                        st_buf_q   <= st_data;
                        word_cnt_q <= 2'd0;
                    end
                    if (kw_ack) begin
                        kw_buf_q <= kw_data;
                    end
                end
                StSub: begin
                    st_buf_q   <= st_merged;
                    word_cnt_q <= word_cnt_q + 2'd1;
                    // Publish only once the last word is done so st_result never shows a
                    // half-updated state between done pulses.
                    if (word_cnt_q == 2'd3) begin
                        st_result_q <= st_merged;
                    end
                end
                KwSub:   kw_result_q <= sub_out;
                default: ;
            endcase
        end
    end

`ifndef SBOX_KW_PRIORITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_kw_q <= 1'b1;
        end else if (st_ack) begin
            last_kw_q <= 1'b0;
        end else if (kw_ack) begin
            last_kw_q <= 1'b1;
        end
    end
`endif

    assign st_done   = (state_q == StFin);
    assign kw_done   = (state_q == KwFin);
    assign busy      = (state_q != Idle);
    assign st_result = st_result_q;
    assign kw_result = kw_result_q;

endmodule

// File: tb/tb_sbox_share_scheduler.sv
// Directed bench for sbox_share_scheduler: known-answer substitutions, latency,
// arbitration between the two requesters, mid-transaction reset and input isolation.
module tb_sbox_share_scheduler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         st_req;
    logic [127:0] st_data;
    logic         st_ack;
    logic         st_done;
    logic [127:0] st_result;
    logic         kw_req;
    logic [31:0]  kw_data;
    logic         kw_ack;
    logic         kw_done;
    logic [31:0]  kw_result;
    logic         busy;

    int errors = 0;
    int checks = 0;

`ifdef SBOX_KW_PRIORITY_EN
    localparam bit KwPrio = 1'b1;
`else
    localparam bit KwPrio = 1'b0;
`endif

    localparam logic [127:0] StIn1  = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] StOut1 = 128'h638293C31BFC33F5C4EEACEA4BC12816;
    localparam logic [31:0]  KwIn1  = 32'hCF4F3C09;
    localparam logic [31:0]  KwOut1 = 32'h8A84EB01;
    localparam logic [127:0] StIn2  = 128'h0000000000FF00000000000000000000;
    localparam logic [127:0] StOut2 = 128'h63636363631663636363636363636363;

    sbox_share_scheduler #(.NUM_SBOX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_req    (st_req),
        .st_data   (st_data),
        .st_ack    (st_ack),
        .st_done   (st_done),
        .st_result (st_result),
        .kw_req    (kw_req),
        .kw_data   (kw_data),
        .kw_ack    (kw_ack),
        .kw_done   (kw_done),
        .kw_result (kw_result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        st_req = 1'b0;
        kw_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Full state transaction from an idle scheduler; perturb flips st_data after acceptance.
    task automatic st_txn(input logic [127:0] d, input logic [127:0] exp, input bit perturb);
        @(negedge clk);
        st_req  = 1'b1;
        st_data = d;
        #1;
        check("st_ack_at_T", st_ack, 1);
        check("kw_ack_at_T", kw_ack, 0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            st_req = 1'b0;
            if (perturb) st_data = ~d;
            #1;
            check("st_busy_in_sub", busy, 1);
            check("st_done_early", st_done, 0);
        end
        @(negedge clk);
        #1;
        check("st_done_at_T5", st_done, 1);
        check("st_result_at_T5", st_result, exp);
        @(negedge clk);
        st_data = '0;
        #1;
        check("st_idle_at_T6", busy, 0);
        check("st_done_at_T6", st_done, 0);
        check("st_result_hold", st_result, exp);
    endtask

    task automatic kw_txn(input logic [31:0] d, input logic [31:0] exp);
        @(negedge clk);
        kw_req  = 1'b1;
        kw_data = d;
        #1;
        check("kw_ack_at_T", kw_ack, 1);
        check("st_ack_at_T", st_ack, 0);
        @(negedge clk);
        kw_req  = 1'b0;
        kw_data = ~d;
        #1;
        check("kw_busy_T1", busy, 1);
        check("kw_done_early", kw_done, 0);
        @(negedge clk);
        #1;
        check("kw_done_at_T2", kw_done, 1);
        check("kw_result_at_T2", kw_result, exp);
        @(negedge clk);
        #1;
        check("kw_idle_at_T3", busy, 0);
        check("kw_result_hold", kw_result, exp);
    endtask

    // Both requests raised together; the loser stays pending until the winner finishes.
    task automatic tie_round(input bit st_first);
        int gap;
        int tail;
        gap  = st_first ? 5 : 2;
        tail = st_first ? 3 : 6;
        @(negedge clk);
        st_req  = 1'b1;
        kw_req  = 1'b1;
        st_data = StIn1;
        kw_data = KwIn1;
        #1;
        check("tie_st_ack", st_ack, st_first);
        check("tie_kw_ack", kw_ack, !st_first);
        for (int i = 1; i <= gap; i++) begin
            @(negedge clk);
            if (st_first) st_req = 1'b0;
            else kw_req = 1'b0;
            #1;
            check("tie_pending_st_ack", st_ack, 0);
            check("tie_pending_kw_ack", kw_ack, 0);
        end
        @(negedge clk);
        #1;
        check("tie_second_st_ack", st_ack, !st_first);
        check("tie_second_kw_ack", kw_ack, st_first);
        for (int i = 1; i <= tail; i++) begin
            @(negedge clk);
            st_req = 1'b0;
            kw_req = 1'b0;
            #1;
        end
        check("tie_end_idle", busy, 0);
        check("tie_st_result", st_result, StOut1);
        check("tie_kw_result", kw_result, KwOut1);
    endtask

    initial begin
        rst_n   = 1'b0;
        st_req  = 1'b0;
        kw_req  = 1'b0;
        st_data = '0;
        kw_data = '0;

        // Reset state, with a request held that must not be acked during reset.
        do_reset();
        st_req = 1'b1;
        #1;
        check("rst_st_ack", st_ack, 0);
        check("rst_kw_ack", kw_ack, 0);
        check("rst_busy", busy, 0);
        check("rst_st_done", st_done, 0);
        check("rst_kw_done", kw_done, 0);
        check("rst_st_result", st_result, 0);
        check("rst_kw_result", kw_result, 0);
        @(negedge clk);
        st_req = 1'b0;
        rst_n  = 1'b1;

        // Known-answer transactions.
        st_txn(StIn1, StOut1, 1'b0);
        kw_txn(KwIn1, KwOut1);
        check("st_result_kept_after_kw", st_result, StOut1);

        // Arbitration after reset, then after a lone state grant.
        do_reset();
        rst_n = 1'b1;
        tie_round(!KwPrio);
        st_txn(StIn1, StOut1, 1'b0);
        tie_round(1'b0);

        // Reset at T+3 of a state transaction aborts it without a done pulse.
        @(negedge clk);
        st_req  = 1'b1;
        st_data = StIn2;
        #1;
        check("abort_st_ack", st_ack, 1);
        @(negedge clk);
        st_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy_before_edge", busy, 1);
        @(negedge clk);
        #1;
        check("abort_busy", busy, 0);
        check("abort_st_done", st_done, 0);
        check("abort_st_result", st_result, 0);
        check("abort_kw_result", kw_result, 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("abort_no_done", st_done, 0);
        check("abort_idle", busy, 0);

        // Fresh request completes; changing st_data mid-flight has no effect.
        st_txn(StIn2, StOut2, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
